mem_access_stage: RTL and testbench

//   MEM stage of the 5-stage RV32 pipeline; sits between the EX/MEM register and mem_wb_reg.

---
 rtl/mem_stage_pkg.sv | 87 ++++++++
 rtl/mem_access_stage_load_align.sv | 26 ++
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV32 MEM stage: funct3 encodings, FSM states,
// WB select codes, payload structs and access helpers.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_PC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_cmd_t;

    typedef struct packed {
        logic              is_load;
        logic [2:0]        f3;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic              rfw;
        logic [SEL_W-1:0]  sel;
    } instr_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic [SEL_W-1:0]  sel;
        logic              rfw;
        logic              mis;
        logic              berr;
    } wb_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [BE_W-1:0] access_be(input logic [2:0] f3, input logic [1:0] a);
        logic [BE_W-1:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: selects the addressed byte/half lane of a read word and sign/zero extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data_c = {24'd0, byte_sel};
            F3_HU:   load_data_c = {16'd0, half_sel};
            default: load_data_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32 pipeline: req/gnt/rvalid data bus access, load alignment, WB forwarding.
// Optional MEM_TIMEOUT_EN: abort a bus access after TIMEOUT waiting cycles with bus_err_out.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic [REG_AW-1:0] addr_rd_in,
    input  logic              reg_file_write_in,
    input  logic [SEL_W-1:0]  select_mux_2_in,
    input  logic [XLEN-1:0]   add_pc_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   mem_data_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [XLEN-1:0]   add_pc_out,
    output logic [REG_AW-1:0] addr_rd_out,
    output logic [SEL_W-1:0]  select_mux_2_out,
    output logic              reg_file_write_out,
    output logic              misaligned_out,
    output logic              bus_err_out
);

    state_e    state_q, state_d;
    logic      req_q, req_d;
    logic      ready_q, ready_d;
    dmem_cmd_t cmd_q, cmd_d;
    instr_t    instr_q, instr_d;
    wb_t       wb_q, wb_d;

    instr_t          in_instr;
    logic            mem_op;
    logic            mis_c;
    logic            done;
    instr_t          done_src;
    logic [XLEN-1:0] done_data;
    logic            done_mis;
    logic            done_berr;
    logic [XLEN-1:0] load_data_c;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT);
`endif

    load_align u_load_align (
        .rdata_i     (dmem_rdata),
        .addr_lo_i   (instr_q.alu[1:0]),
        .funct3_i    (instr_q.f3),
        .load_data_c (load_data_c)
    );

    // Next-state, bus command and writeback result
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        instr_d    = instr_q;
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        done       = 1'b0;
        done_src   = instr_q;
        done_data  = '0;
        done_mis   = 1'b0;
        done_berr  = 1'b0;

        mem_op           = mem_read_in | mem_write_in;
        mis_c            = is_misaligned(funct3_in, alu_result_in[1:0]);
        in_instr.is_load = mem_read_in & ~mem_write_in;
        in_instr.f3      = funct3_in;
        in_instr.alu     = alu_result_in;
        in_instr.pc      = add_pc_in;
        in_instr.rd      = addr_rd_in;
        in_instr.rfw     = reg_file_write_in;
        in_instr.sel     = select_mux_2_in;

`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
        timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    instr_d = in_instr;
                    if (mem_op && !mis_c) begin
                        state_d     = REQ;
                        req_d       = 1'b1;
                        cmd_d.we    = mem_write_in;
                        cmd_d.addr  = {alu_result_in[XLEN-1:2], 2'b00};
                        cmd_d.wdata = mem_write_in ? store_wdata(funct3_in, store_data_in) : '0;
                        cmd_d.be    = access_be(funct3_in, alu_result_in[1:0]);
`ifdef MEM_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        done     = 1'b1;
                        done_src = in_instr;
                        done_mis = mem_op;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    cmd_d = '0;
                    if (!instr_q.is_load) begin
                        done = 1'b1;
                    end else if (dmem_rvalid) begin
                        done      = 1'b1;
                        done_data = load_data_c;
                    end else begin
                        state_d = RESP;
`ifdef MEM_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    req_d     = 1'b0;
                    cmd_d     = '0;
                    done      = 1'b1;
                    done_berr = 1'b1;
                end
`endif
            end
            RESP: begin
                if (dmem_rvalid) begin
                    done      = 1'b1;
                    done_data = load_data_c;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    done      = 1'b1;
                    done_berr = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d    = IDLE;
            wb_d.valid = 1'b1;
            wb_d.data  = done_data;
            wb_d.alu   = done_src.alu;
            wb_d.pc    = done_src.pc;
            wb_d.rd    = done_src.rd;
            wb_d.sel   = done_src.sel;
            wb_d.rfw   = done_src.rfw & ~done_mis & ~done_berr;
            wb_d.mis   = done_mis;
            wb_d.berr  = done_berr;
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            ready_q <= 1'b0;
            cmd_q   <= '0;
            instr_q <= '0;
            wb_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
            instr_q <= instr_d;
            wb_q    <= wb_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign in_ready           = ready_q;
    assign dmem_req           = req_q;
    assign dmem_we            = cmd_q.we;
    assign dmem_addr          = cmd_q.addr;
    assign dmem_wdata         = cmd_q.wdata;
    assign dmem_be            = cmd_q.be;
    assign out_valid          = wb_q.valid;
    assign mem_data_out       = wb_q.data;
    assign alu_result_out     = wb_q.alu;
    assign add_pc_out         = wb_q.pc;
    assign addr_rd_out        = wb_q.rd;
    assign select_mux_2_out   = wb_q.sel;
    assign reg_file_write_out = wb_q.rfw;
    assign misaligned_out     = wb_q.mis;
    assign bus_err_out        = wb_q.berr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected WB results queued at issue, checked on out_valid.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic        rfw;
        logic        mis;
        logic        berr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [2:0]  funct3_in = 3'd0;
    logic [31:0] alu_result_in = 32'd0;
    logic [31:0] store_data_in = 32'd0;
    logic [4:0]  addr_rd_in = 5'd0;
    logic        reg_file_write_in = 1'b0;
    logic [1:0]  select_mux_2_in = 2'd0;
    logic [31:0] add_pc_in = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        out_valid;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_out;
    logic [31:0] add_pc_out;
    logic [4:0]  addr_rd_out;
    logic [1:0]  select_mux_2_out;
    logic        reg_file_write_out;
    logic        misaligned_out;
    logic        bus_err_out;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .funct3_in(funct3_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .addr_rd_in(addr_rd_in),
        .reg_file_write_in(reg_file_write_in), .select_mux_2_in(select_mux_2_in),
        .add_pc_in(add_pc_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .mem_data_out(mem_data_out),
        .alu_result_out(alu_result_out), .add_pc_out(add_pc_out),
        .addr_rd_out(addr_rd_out), .select_mux_2_out(select_mux_2_out),
        .reg_file_write_out(reg_file_write_out), .misaligned_out(misaligned_out),
        .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single cycle and queue its expected WB result
    task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic rfw, input logic [1:0] sel, input logic [31:0] exp_data,
                         input logic exp_mis, input logic exp_berr);
        exp_t e;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        in_valid          = 1'b1;
        mem_read_in       = rd_op;
        mem_write_in      = wr_op;
        funct3_in         = f3;
        alu_result_in     = addr;
        store_data_in     = sdata;
        addr_rd_in        = rd;
        reg_file_write_in = rfw;
        select_mux_2_in   = sel;
        add_pc_in         = addr + 32'h1000;
        e.data = exp_data;
        e.alu  = addr;
        e.pc   = addr + 32'h1000;
        e.rd   = rd;
        e.sel  = sel;
        e.rfw  = rfw & ~exp_mis & ~exp_berr;
        e.mis  = exp_mis;
        e.berr = exp_berr;
        sb.push_back(e);
        tick();
        in_valid     = 1'b0;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
    endtask

    // Bus responder: gnt after gnt_wait cycles, rvalid rv_wait cycles after gnt (0 = same cycle)
    task automatic bus_txn(input int gnt_wait, input bit is_load, input int rv_wait,
                           input logic [31:0] rdata, output int busy);
        busy = 0;
        for (int i = 0; i < gnt_wait; i++) begin
            chk("req_held", 32'(dmem_req), 32'd1);
            if (!in_ready) busy++;
            tick();
        end
        chk("req_at_gnt", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        if (is_load && rv_wait == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
        end
        if (!in_ready) busy++;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (is_load && rv_wait > 0) begin
            for (int i = 1; i < rv_wait; i++) begin
                if (!in_ready) busy++;
                tick();
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            if (!in_ready) busy++;
            tick();
            dmem_rvalid = 1'b0;
        end
    endtask

    // Scoreboard: every completed instruction must match the oldest queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset && out_valid) begin
            chk("out_valid_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("mem_data_out", mem_data_out, e.data);
                chk("alu_result_out", alu_result_out, e.alu);
                chk("add_pc_out", add_pc_out, e.pc);
                chk("addr_rd_out", 32'(addr_rd_out), 32'(e.rd));
                chk("select_mux_2_out", 32'(select_mux_2_out), 32'(e.sel));
                chk("reg_file_write_out", 32'(reg_file_write_out), 32'(e.rfw));
                chk("misaligned_out", 32'(misaligned_out), 32'(e.mis));
                chk("bus_err_out", 32'(bus_err_out), 32'(e.berr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int w;
        #1 reset = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_data", mem_data_out, 32'd0);
        chk("rst_rfw", 32'(reg_file_write_out), 32'd0);
        chk("rst_bus_err", 32'(bus_err_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // LW 0x100, gnt with req, rvalid two cycles later
        issue(1'b1, 1'b0, F3_W, 32'h100, 32'd0, 5'd1, 1'b1, WB_MEM, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("lw_req", 32'(dmem_req), 32'd1);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_we", 32'(dmem_we), 32'd0);
        chk("lw_be", 32'(dmem_be), 32'hF);
        bus_txn(0, 1'b1, 2, 32'hDEADBEEF, busy);
        chk("lw_busy_cycles", 32'(busy), 32'd3);
        chk("lw_ready_after", 32'(in_ready), 32'd1);
        chk("lw_req_dropped", 32'(dmem_req), 32'd0);

        issue(1'b1, 1'b0, F3_B, 32'h103, 32'd0, 5'd2, 1'b1, WB_MEM, 32'hFFFFFF80, 1'b0, 1'b0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_be", 32'(dmem_be), 32'h8);
        bus_txn(1, 1'b1, 1, 32'h80FF0000, busy);

        issue(1'b1, 1'b0, F3_BU, 32'h103, 32'd0, 5'd3, 1'b1, WB_MEM, 32'h00000080, 1'b0, 1'b0);
        bus_txn(0, 1'b1, 3, 32'h80FF0000, busy);

        issue(1'b1, 1'b0, F3_H, 32'h102, 32'd0, 5'd4, 1'b1, WB_MEM, 32'hFFFF80FF, 1'b0, 1'b0);
        chk("lh_be", 32'(dmem_be), 32'hC);
        bus_txn(2, 1'b1, 1, 32'h80FF0000, busy);

        // rvalid in the gnt cycle
        issue(1'b1, 1'b0, F3_HU, 32'h102, 32'd0, 5'd5, 1'b1, WB_MEM, 32'h000080FF, 1'b0, 1'b0);
        bus_txn(0, 1'b1, 0, 32'h80FF0000, busy);
        chk("lhu_same_cycle_busy", 32'(busy), 32'd1);

        // SH 0x206 with gnt held off
        issue(1'b0, 1'b1, F3_H, 32'h206, 32'h1234ABCD, 5'd0, 1'b0, WB_ALU, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", 32'(dmem_req), 32'd1);
            chk("sh_we", 32'(dmem_we), 32'd1);
            chk("sh_addr", dmem_addr, 32'h204);
            chk("sh_be", 32'(dmem_be), 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
            tick();
        end
        bus_txn(0, 1'b0, 0, 32'd0, busy);
        chk("sh_ready_after", 32'(in_ready), 32'd1);
        chk("sh_req_dropped", 32'(dmem_req), 32'd0);

        issue(1'b0, 1'b1, F3_B, 32'h301, 32'h000000A5, 5'd0, 1'b0, WB_ALU, 32'd0, 1'b0, 1'b0);
        chk("sb_addr", dmem_addr, 32'h300);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        bus_txn(1, 1'b0, 0, 32'd0, busy);

        // read and write both set behaves as a store
        issue(1'b1, 1'b1, F3_W, 32'h500, 32'hCAFEF00D, 5'd6, 1'b0, WB_ALU, 32'd0, 1'b0, 1'b0);
        chk("rw_we", 32'(dmem_we), 32'd1);
        chk("rw_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("rw_be", 32'(dmem_be), 32'hF);
        bus_txn(0, 1'b0, 0, 32'd0, busy);
        chk("rw_busy_cycles", 32'(busy), 32'd1);

        // non-memory op: single-cycle
        issue(1'b0, 1'b0, F3_W, 32'h55, 32'd0, 5'd7, 1'b1, WB_ALU, 32'd0, 1'b0, 1'b0);
        chk("alu_latency", 32'(out_valid), 32'd1);
        chk("alu_no_req", 32'(dmem_req), 32'd0);
        issue(1'b0, 1'b0, F3_B, 32'h2000, 32'd0, 5'd1, 1'b1, WB_PC, 32'd0, 1'b0, 1'b0);
        chk("pc_latency", 32'(out_valid), 32'd1);

        // misaligned accesses never reach the bus
        issue(1'b1, 1'b0, F3_W, 32'h102, 32'd0, 5'd9, 1'b1, WB_MEM, 32'd0, 1'b1, 1'b0);
        chk("mis_lw_latency", 32'(out_valid), 32'd1);
        chk("mis_lw_no_req", 32'(dmem_req), 32'd0);
        issue(1'b0, 1'b1, F3_H, 32'h203, 32'h1111, 5'd0, 1'b1, WB_ALU, 32'd0, 1'b1, 1'b0);
        chk("mis_sh_no_req", 32'(dmem_req), 32'd0);
        issue(1'b1, 1'b0, F3_H, 32'h101, 32'd0, 5'd10, 1'b1, WB_MEM, 32'd0, 1'b1, 1'b0);
        chk("mis_lh_no_req", 32'(dmem_req), 32'd0);
        chk("mis_lh_ready", 32'(in_ready), 32'd1);

        // reset asserted while waiting for rvalid
        issue(1'b1, 1'b0, F3_W, 32'h700, 32'd0, 5'd11, 1'b1, WB_MEM, 32'h0BADF00D, 1'b0, 1'b0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("resp_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_alu_out", alu_result_out, 32'd0);
        chk("mid_rst_pc_out", add_pc_out, 32'd0);
        chk("mid_rst_rd_out", 32'(addr_rd_out), 32'd0);
        chk("mid_rst_mis", 32'(misaligned_out), 32'd0);
        chk("mid_rst_rfw", 32'(reg_file_write_out), 32'd0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0BADF00D;
        reset = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_abort_no_valid", 32'(out_valid), 32'd0);
            chk("post_abort_no_req", 32'(dmem_req), 32'd0);
            tick();
        end
        chk("post_abort_ready", 32'(in_ready), 32'd1);
        issue(1'b0, 1'b0, F3_W, 32'h77, 32'd0, 5'd12, 1'b1, WB_ALU, 32'd0, 1'b0, 1'b0);
        chk("recover_latency", 32'(out_valid), 32'd1);

`ifdef MEM_TIMEOUT_EN
        issue(1'b1, 1'b0, F3_W, 32'h600, 32'd0, 5'd13, 1'b1, WB_MEM, 32'd0, 1'b0, 1'b1);
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        chk("timeout_wait_cycles", 32'(w), 32'd4);
        chk("timeout_req_dropped", 32'(dmem_req), 32'd0);
`else
        w = 0;
`endif

        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
